psum_acc: RTL and testbench
===========================

Name: psum_acc

Overview:
- Partial-sum accumulation controller that sits directly around the n1 multiply-add stage.
- Holds the running partial sum and drives it into n1's nbout operand. Captures n1's result on each valid term, counts terms, and emits the final neuron sum downstream with a valid/ready handshake.
- Arithmetic (multiply, add, N-bit wrap) lives in n1. This block is pure sequencing and storage.

Parameters:
- N, 16, data width of partial sums; matches n1 N.
- CNT_W, 8, width of term counter; max terms per neuron = 2^CNT_W - 1.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  pulse: begin new neuron accumulation; sampled only in IDLE or on the OUT handshake cycle.
- i_len  in  CNT_W  number of terms for this neuron; sampled with i_start.
- i_valid  in  1  n1 result on i_res is a valid term.
- o_ready  out  1  block accepts a term this cycle.
- i_res  in  N  n1 o_res (nbout + nbin*sb).
- o_nbout  out  N  current partial sum register; wired to n1 i_nbout.
- o_valid  out  1  final sum available.
- i_ready  in  1  downstream accepts final sum.
- o_sum  out  N  final neuron sum.
- o_busy  out  1  high whenever state != IDLE.

Behaviour:
- State machine states: IDLE, ACC, OUT. All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- Reset (i_rst=1 at edge): state=IDLE, psum=0, count=0.
  - Outputs after reset: o_nbout=0, o_sum=0, o_valid=0, o_ready=0, o_busy=0.
  - Reset overrides every other input, including mid-ACC and mid-OUT. No partial result is emitted.
- IDLE:
  - o_ready=0, o_valid=0.
  - i_start=1 with i_len!=0: psum<=0, count<=i_len, go ACC.
  - i_start=1 with i_len==0: psum<=0, go OUT; the empty neuron yields sum 0.
  - i_valid is ignored in IDLE.
- ACC:
  - o_ready=1.
  - Term accepted when i_valid & o_ready: psum<=i_res, count<=count-1.
  - Accepting the term with count==1: go OUT. o_valid rises the cycle after the last accepted term (latency 1).
  - i_valid=0: hold psum and count. Gaps of any length are allowed.
  - i_start is ignored in ACC.
- OUT:
  - o_valid=1, o_ready=0, o_sum=psum.
  - o_sum and o_nbout are held stable while i_ready=0, for any number of cycles.
  - Handshake is o_valid & i_ready.
    - With i_start=0: go IDLE.
    - With i_start=1: treated as a new start. psum<=0, count<=i_len, go ACC; or go OUT again if i_len==0.
- Width rules:
  - psum is stored exactly as received, N bits. No saturation or extension; wrap-around is n1's modulo-2^N result.
  - count is unsigned CNT_W bits.
- o_sum equals psum at all times. It is meaningful only while o_valid=1.

Test Plan:
- Basic: bench models n1 as i_res=o_nbout+a*b. Start with i_len=3; terms (2,3),(4,5),(1,7) on consecutive cycles -> o_nbout steps 0,6,26,33. o_valid=1 with o_sum=33 one cycle after the third term.
- Gaps plus backpressure: i_len=2, terms (3,3),(2,2) separated by 4 idle cycles; i_ready=0 for 5 cycles after o_valid -> o_sum stays 13 and o_valid stays 1 throughout. Handshake on cycle 6 returns to IDLE, o_busy=0.
- Empty neuron: i_start with i_len=0 -> o_valid=1, o_sum=0 on the next cycle; no term is accepted.
- Wrap-around: i_len=2, i_res driven as 0xFFFF then 0x0001 -> o_sum=0x0001; no saturation.
- Back-to-back plus ignored start:
  - i_start pulsed mid-ACC -> no effect on count or psum.
  - i_start with i_len=1 on the OUT handshake cycle -> state goes ACC with psum=0 next cycle. The following term (5,5) yields o_sum=25.
- Reset mid-operation: assert i_rst after 2 of 4 terms -> next cycle o_busy=0, o_nbout=0, o_valid=0. No o_valid pulse appears until a new i_start sequence completes.

Source files
------------

// File: rtl/psum_acc.sv
// rtl/psum_acc.sv - partial-sum accumulation controller wrapped around the n1 multiply-add stage
module psum_acc #(
   parameter int N     = 16,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_len,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [N-1:0]     i_res,
   output logic [N-1:0]     o_nbout,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [N-1:0]     o_sum,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [N-1:0]     psum, psum_n;
   logic [CNT_W-1:0] count, count_n;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         psum  <= '0;
         count <= '0;
      end else begin
         state <= state_n;
         psum  <= psum_n;
         count <= count_n;
      end
   end

   // A start with a zero length skips ACC entirely and presents an empty (zero) sum.
   always_comb begin
      state_n = state;
      psum_n  = psum;
      count_n = count;
      unique case (state)
         IDLE: begin
            if (i_start) begin
               psum_n  = '0;
               count_n = i_len;
               state_n = (i_len == '0) ? OUT : ACC;
            end
         end
         ACC: begin
            if (i_valid) begin
               psum_n  = i_res;
               count_n = count - 1'b1;
               if (count == {{(CNT_W-1){1'b0}}, 1'b1})
                  state_n = OUT;
            end
         end
         OUT: begin
            if (i_ready) begin
               if (i_start) begin
                  psum_n  = '0;
                  count_n = i_len;
                  state_n = (i_len == '0) ? OUT : ACC;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Every output comes straight from registers or the state decode.
   assign o_ready = (state == ACC);
   assign o_valid = (state == OUT);
   assign o_busy  = (state != IDLE);
   assign o_nbout = psum;
   assign o_sum   = psum;

endmodule

// File: tb/tb_psum_acc.sv
// tb/tb_psum_acc.sv - self-checking bench for psum_acc with an n1 stand-in and a neuron-level model
module tb_psum_acc;

   localparam int N     = 16;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] len = '0;
   logic             valid = 1'b0;
   logic             ready_out;
   logic [N-1:0]     res;
   logic [N-1:0]     nbout;
   logic             valid_out;
   logic             ready_in = 1'b0;
   logic [N-1:0]     sum;
   logic             busy;

   logic [7:0]       a = '0, b = '0;
   logic             direct = 1'b0;
   logic [N-1:0]     res_direct = '0;

   int errors = 0;
   int checks = 0;
   bit checking_on = 1'b0;

   always #5 clk = ~clk;

   // n1 stand-in: nbout + a*b, or a forced value for wrap tests
   assign res = direct ? res_direct : N'(nbout + a * b);

   psum_acc #(.N(N), .CNT_W(CNT_W)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_len   (len),
      .i_valid (valid),
      .o_ready (ready_out),
      .i_res   (res),
      .o_nbout (nbout),
      .o_valid (valid_out),
      .i_ready (ready_in),
      .o_sum   (sum),
      .o_busy  (busy)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Neuron-level model: is a neuron in progress, how many terms remain, is a sum waiting
   bit         m_collecting = 1'b0;
   bit         m_waiting    = 1'b0;
   int         m_left       = 0;
   bit [N-1:0] m_total      = '0;

   always @(posedge clk) begin
      bit [N-1:0] term_res;
      bit         take_start;
      term_res = direct ? res_direct : N'(m_total + a * b);
      take_start = 1'b0;
      if (rst) begin
         m_collecting = 0; m_waiting = 0; m_left = 0; m_total = '0;
      end else if (m_waiting) begin
         if (ready_in) begin
            m_waiting = 0;
            take_start = start;
         end
      end else if (m_collecting) begin
         if (valid) begin
            m_total = term_res;
            m_left  = m_left - 1;
            if (m_left == 0) begin
               m_collecting = 0;
               m_waiting = 1;
            end
         end
      end else begin
         take_start = start;
      end
      if (take_start) begin
         m_total = '0;
         m_left  = int'(len);
         if (len == 0) m_waiting = 1;
         else m_collecting = 1;
      end
   end

   always @(negedge clk) begin
      if (checking_on) begin
         check("model_nbout", int'(nbout), int'(m_total));
         check("model_valid", int'(valid_out), int'(m_waiting));
         check("model_ready", int'(ready_out), int'(m_collecting));
         check("model_busy",  int'(busy), int'(m_collecting | m_waiting));
         if (m_waiting) check("model_sum", int'(sum), int'(m_total));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic term(input int ta, input int tb_);
      valid = 1'b1; a = 8'(ta); b = 8'(tb_);
      tick();
      valid = 1'b0;
   endtask

   task automatic begin_neuron(input int l);
      start = 1'b1; len = CNT_W'(l);
      tick();
      start = 1'b0;
   endtask

   task automatic handshake();
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
   endtask

   initial begin
      tick();
      rst = 1'b0;
      checking_on = 1'b1;
      check("rst_nbout", int'(nbout), 0);
      check("rst_sum",   int'(sum), 0);
      check("rst_valid", int'(valid_out), 0);
      check("rst_ready", int'(ready_out), 0);
      check("rst_busy",  int'(busy), 0);

      // basic: (2,3),(4,5),(1,7)
      begin_neuron(3);
      check("basic_nbout0", int'(nbout), 0);
      check("basic_ready", int'(ready_out), 1);
      valid = 1'b1; a = 2; b = 3; tick();
      check("basic_nbout1", int'(nbout), 6);
      a = 4; b = 5; tick();
      check("basic_nbout2", int'(nbout), 26);
      a = 1; b = 7; tick();
      valid = 1'b0;
      check("basic_sum", int'(sum), 33);
      check("basic_valid", int'(valid_out), 1);
      handshake();
      check("basic_idle", int'(busy), 0);

      // gaps plus backpressure
      begin_neuron(2);
      term(3, 3);
      repeat (4) tick();
      check("gap_hold", int'(nbout), 9);
      term(2, 2);
      for (int i = 0; i < 5; i++) begin
         check("bp_sum", int'(sum), 13);
         check("bp_valid", int'(valid_out), 1);
         tick();
      end
      handshake();
      check("bp_idle", int'(busy), 0);
      check("bp_valid_drop", int'(valid_out), 0);

      // empty neuron; a valid in IDLE must be ignored
      valid = 1'b1; a = 9; b = 9;
      begin_neuron(0);
      check("empty_valid", int'(valid_out), 1);
      check("empty_sum", int'(sum), 0);
      tick();
      valid = 1'b0;
      check("empty_hold", int'(sum), 0);
      handshake();

      // wrap-around
      direct = 1'b1;
      begin_neuron(2);
      valid = 1'b1; res_direct = 16'hFFFF; tick();
      check("wrap_first", int'(nbout), 'hFFFF);
      res_direct = 16'h0001; tick();
      valid = 1'b0; direct = 1'b0;
      check("wrap_sum", int'(sum), 1);
      check("wrap_valid", int'(valid_out), 1);
      handshake();

      // ignored start mid-ACC, then back-to-back start on handshake
      begin_neuron(3);
      term(1, 1);
      begin_neuron(7);
      check("ign_start_nbout", int'(nbout), 1);
      check("ign_start_ready", int'(ready_out), 1);
      term(2, 2);
      term(3, 3);
      check("b2b_first_sum", int'(sum), 14);
      start = 1'b1; len = 1; ready_in = 1'b1;
      tick();
      start = 1'b0; ready_in = 1'b0;
      check("b2b_acc", int'(ready_out), 1);
      check("b2b_nbout0", int'(nbout), 0);
      check("b2b_valid_low", int'(valid_out), 0);
      term(5, 5);
      check("b2b_sum", int'(sum), 25);
      check("b2b_valid", int'(valid_out), 1);
      handshake();

      // reset after two of four terms
      begin_neuron(4);
      term(1, 2);
      term(3, 4);
      check("pre_rst_nbout", int'(nbout), 14);
      rst = 1'b1; tick(); rst = 1'b0;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_nbout", int'(nbout), 0);
      check("mid_rst_valid", int'(valid_out), 0);
      term(6, 6);
      term(6, 6);
      repeat (3) tick();
      check("post_rst_quiet", int'(valid_out), 0);
      begin_neuron(1);
      term(2, 3);
      check("post_rst_sum", int'(sum), 6);
      handshake();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
